mem_access_controller: RTL and testbench
========================================

# mem_access_controller

Sequential load/store engine that consumes the memory-control outputs of the instruction decoder (`read_mem`, `write_mem`, `load_byte`, `store_byte`) and executes them as handshaked transactions on the data bus. It sits between the execute stage and data memory: it latches the request, drives byte-lane strobes, waits out memory wait-states, returns aligned/sign-extended load data, and stalls the pipeline until the access retires.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width
- `DATA_W`, 32, data width; fixed at 32, with 4 byte lanes

Ports:
- `clk`  in  1  core clock, rising edge
- `nRst`  in  1  reset, asynchronous, active-low
- `read_mem`  in  1  load request from the decoder
- `write_mem`  in  1  store request from the decoder
- `load_byte`  in  1  load is LB (sign-extended); else LW
- `store_byte`  in  1  store is SB; else SW
- `addr`  in  ADDR_W  effective byte address from the ALU
- `store_data`  in  32  rs2 value
- `stall`  out  1  hold the pipeline
- `done`  out  1  one-cycle pulse when the access retires
- `load_data`  out  32  load result, valid while `done`=1
- `misaligned`  out  1  misaligned-word pulse (see Configuration)
- `bus_addr`  out  ADDR_W  word-aligned address `{addr[31:2],2'b00}`
- `bus_wdata`  out  32  write data
- `bus_sel`  out  4  byte-lane enables
- `bus_ren`  out  1  read strobe
- `bus_wen`  out  1  write strobe
- `bus_rdata`  in  32  read data from memory
- `bus_busy`  in  1  memory wait-state; 0 = completes this cycle

## Operation
- States: IDLE, REQ, DONE.
- **IDLE**
  - If `read_mem|write_mem`: latch `addr`, `store_data`, the direction and the byte flag, then go to REQ.
  - If both `read_mem` and `write_mem` are asserted, the write wins.
  - `stall` is combinationally 1 whenever a request is present in IDLE.
- **REQ**
  - Bus outputs are driven only from the latched registers. Pipeline inputs are ignored.
  - `bus_ren`/`bus_wen` are held high until a cycle in which `bus_busy`=0. At that edge go to DONE.
  - On a read, capture the lane-selected `bus_rdata` into `load_data` at that same edge.
  - `stall`=1 throughout REQ.
- **DONE**
  - `done`=1, `stall`=0, all strobes 0. Always returns to IDLE next cycle.
  - The pipeline advances at the end of DONE, so a request seen in the following IDLE belongs to the next instruction.
- **Lane rules**
  - SW: `bus_sel`=4'b1111, `bus_wdata`=`store_data`.
  - SB: `bus_sel`=`4'b0001<<addr[1:0]`, `bus_wdata`=`{4{store_data[7:0]}}`.
  - LW: `bus_sel`=4'b1111, `load_data`=`bus_rdata`.
  - LB: `bus_sel`=`4'b0001<<addr[1:0]`. `load_data` is the selected byte `bus_rdata[8*addr[1:0]+:8]` sign-extended to 32 bits.
- **Outputs during stores and in IDLE**
  - Stores leave `load_data` unchanged.
  - In IDLE, `bus_sel`, `bus_wdata` and `bus_addr` hold their last values. Only the strobes qualify them.

## Timing
- Reset (async assert, sync deassert by the environment):
  - State IDLE.
  - `load_data`, `bus_addr`, `bus_wdata` = 0; `bus_sel`=0.
  - `bus_ren`, `bus_wen`, `done`, `misaligned` = 0.
  - `stall`=0 unless a request is present.
- Reset asserted mid-REQ drops the strobes immediately (asynchronously) and abandons the access.
- Minimum latency with a zero-wait memory: request seen in cycle 0, strobes in cycle 1, `done` in cycle 2. The result is 2 stall cycles.
- Each wait-state cycle (`bus_busy`=1 in REQ) adds exactly one cycle.
- `bus_rdata` is sampled only on the REQ edge where `bus_busy`=0.
- At most one transaction is outstanding. There is no back-to-back issue without passing through DONE.

## Configuration
- Macro `MISALIGN_TRAP_EN`.
- **Defined:** a word access (LW/SW) with `addr[1:0]`≠0 issues no bus strobe.
  - IDLE goes straight to DONE.
  - DONE asserts `misaligned`=1 together with `done`=1.
  - `load_data` is forced to 0.
  - The result is 1 stall cycle.
- **Undefined:** `addr[1:0]` is ignored for word accesses, which access the aligned word. `misaligned` is tied 0.

## Test plan
- **Zero-wait LW:** `addr`=0x100, `bus_rdata`=0xDEADBEEF, `bus_busy`=0.
  - `bus_ren`=1 and `bus_sel`=4'hF in cycle 1.
  - `done`=1 and `load_data`=0xDEADBEEF in cycle 2; `stall` high for cycles 0–1.
- **SB with 3 wait-states:** `addr`=0x203, `store_data`=0x000000A5, `bus_busy`=1 for 3 cycles.
  - `bus_sel`=4'b1000, `bus_wdata`=0xA5A5A5A5, `bus_addr`=0x200.
  - `bus_wen` high for 4 cycles; `done` in cycle 5.
- **LB sign-extension:** `addr`=0x41, `bus_rdata`=0x12348056 → `load_data`=0x00000080 sign-extended = 0xFFFFFF80.
- **Simultaneous `read_mem`+`write_mem`:** only `bus_wen` is asserted and `load_data` is unchanged.
- **Reset mid-REQ:** drop `nRst` while `bus_busy`=1.
  - Strobes go 0 within the same cycle; all outputs return to reset values.
  - After release, a new LW completes normally.
- **Misaligned SW at `addr`=0x102:**
  - With `MISALIGN_TRAP_EN`: no strobe, and `done`=`misaligned`=1 in cycle 1.
  - Without it: `bus_addr`=0x100, `bus_sel`=4'hF, `misaligned`=0.

Source files
------------

// File: rtl/mem_access_controller_if.sv
// Data-bus bundle between the load/store engine and data memory.
// Master drives address, lanes and strobes; slave returns data and wait-state.
interface mem_access_controller_if #(
  parameter int ADDR_W = 32
) ();
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic [3:0]        bus_sel;
  logic              bus_ren;
  logic              bus_wen;
  logic [31:0]       bus_rdata;
  logic              bus_busy;

  modport master (
    output bus_addr, bus_wdata, bus_sel,
    output bus_ren, bus_wen,
    input  bus_rdata, bus_busy
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_sel,
    input  bus_ren, bus_wen,
    output bus_rdata, bus_busy
  );
endinterface

// File: rtl/mem_access_controller.sv
// Sequential load/store engine: one handshaked bus access per LW/LB/SW/SB.
// MISALIGN_TRAP_EN: misaligned word accesses skip the bus and pulse misaligned.
module mem_access_controller #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              read_mem,
  input  logic              write_mem,
  input  logic              load_byte,
  input  logic              store_byte,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] load_data,
  output logic              misaligned,
  mem_access_controller_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic       req;
  logic       byte_sel;
  logic       trap;
  logic       wr_r;
  logic       byte_r;
  logic [1:0] lane_r;
  logic       mis_r;
  logic [7:0] rbyte;

  assign req      = read_mem | write_mem;
  assign byte_sel = write_mem ? store_byte : load_byte;
  assign rbyte    = bus.bus_rdata[8*lane_r +: 8];

`ifdef MISALIGN_TRAP_EN
  assign trap = !byte_sel && (addr[1:0] != 2'b00);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst)
      mis_r <= 1'b0;
    else if (state == IDLE && req)
      mis_r <= trap;
  end
`else
  assign trap  = 1'b0;
  assign mis_r = 1'b0;
`endif

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (req) state_nx = trap ? DONE : REQ;
      REQ:  if (!bus.bus_busy) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Strobes decode from state alone so an async reset drops them at once.
  always_comb begin
    stall       = 1'b0;
    done        = 1'b0;
    misaligned  = 1'b0;
    bus.bus_ren = 1'b0;
    bus.bus_wen = 1'b0;
    unique case (state)
      IDLE: stall = req;
      REQ: begin
        stall       = 1'b1;
        bus.bus_ren = !wr_r;
        bus.bus_wen = wr_r;
      end
      DONE: begin
        done       = 1'b1;
        misaligned = mis_r;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wr_r          <= 1'b0;
      byte_r        <= 1'b0;
      lane_r        <= 2'b00;
      load_data     <= '0;
      bus.bus_addr  <= '0;
      bus.bus_wdata <= '0;
      bus.bus_sel   <= 4'b0000;
    end else begin
      if (state == IDLE && req) begin
        wr_r         <= write_mem;
        byte_r       <= byte_sel;
        lane_r       <= addr[1:0];
        bus.bus_addr <= {addr[ADDR_W-1:2], 2'b00};
        bus.bus_sel  <= byte_sel ? (4'b0001 << addr[1:0]) : 4'b1111;
        bus.bus_wdata <= (write_mem && store_byte) ?
                         {4{store_data[7:0]}} : store_data;
        if (trap && !write_mem)
          load_data <= '0;
      end
      if (state == REQ && !bus.bus_busy && !wr_r)
        load_data <= byte_r ? {{24{rbyte[7]}}, rbyte} : bus.bus_rdata;
    end
  end

endmodule

// File: tb/tb_mem_access_controller.sv
// Directed bench for mem_access_controller: LW, LB, SB with wait-states,
// read+write collision, reset mid-access and misaligned word store.
module tb_mem_access_controller;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        read_mem = 1'b0;
  logic        write_mem = 1'b0;
  logic        load_byte = 1'b0;
  logic        store_byte = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        misaligned;

  int total = 0;
  int bad = 0;

  mem_access_controller_if #(.ADDR_W(32)) bif ();

  mem_access_controller #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .nRst       (nRst),
    .read_mem   (read_mem),
    .write_mem  (write_mem),
    .load_byte  (load_byte),
    .store_byte (store_byte),
    .addr       (addr),
    .store_data (store_data),
    .stall      (stall),
    .done       (done),
    .load_data  (load_data),
    .misaligned (misaligned),
    .bus        (bif.master)
  );

  always #5 clk = ~clk;

  // Present a request right after a rising edge; that cycle is cycle 0.
  task automatic issue(input logic rd, input logic wr, input logic lb,
                       input logic sb, input logic [31:0] a,
                       input logic [31:0] d);
    @(posedge clk); #1;
    read_mem = rd; write_mem = wr; load_byte = lb; store_byte = sb;
    addr = a; store_data = d;
  endtask

  task automatic drop_req();
    @(posedge clk); #1;
    read_mem = 1'b0; write_mem = 1'b0;
    load_byte = 1'b0; store_byte = 1'b0;
  endtask

  task automatic test_reset();
    bif.bus_rdata = '0; bif.bus_busy = 1'b0;
    #12;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%h want=0", stall); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%h want=0", done); end
    total++; if ({bif.bus_ren, bif.bus_wen} !== 2'b00) begin bad++; $display("FAIL rst_strobes got=%b want=00", {bif.bus_ren, bif.bus_wen}); end
    total++; if (load_data !== 32'h0) begin bad++; $display("FAIL rst_load_data got=%h want=0", load_data); end
    total++; if (bif.bus_addr !== 32'h0 || bif.bus_wdata !== 32'h0 || bif.bus_sel !== 4'h0) begin bad++; $display("FAIL rst_bus got=%h/%h/%h want=0/0/0", bif.bus_addr, bif.bus_wdata, bif.bus_sel); end
    total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL rst_misaligned got=%h want=0", misaligned); end
    read_mem = 1'b1; #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL rst_stall_req got=%h want=1", stall); end
    read_mem = 1'b0;
    @(negedge clk); nRst = 1'b1;
  endtask

  task automatic test_lw();
    bif.bus_rdata = 32'hDEADBEEF; bif.bus_busy = 1'b0;
    issue(1, 0, 0, 0, 32'h100, 32'h0);
    @(negedge clk);
    total++; if (stall !== 1'b1 || bif.bus_ren !== 1'b0) begin bad++; $display("FAIL lw_c0 got=stall%h ren%h want=stall1 ren0", stall, bif.bus_ren); end
    drop_req();
    @(negedge clk);
    total++; if (bif.bus_ren !== 1'b1 || bif.bus_wen !== 1'b0 || bif.bus_sel !== 4'hF) begin bad++; $display("FAIL lw_c1_bus got=ren%h wen%h sel%h want=ren1 wen0 self", bif.bus_ren, bif.bus_wen, bif.bus_sel); end
    total++; if (stall !== 1'b1 || bif.bus_addr !== 32'h100) begin bad++; $display("FAIL lw_c1 got=stall%h addr%h want=stall1 addr100", stall, bif.bus_addr); end
    @(negedge clk);
    total++; if (done !== 1'b1 || stall !== 1'b0 || bif.bus_ren !== 1'b0) begin bad++; $display("FAIL lw_c2 got=done%h stall%h ren%h want=1 0 0", done, stall, bif.bus_ren); end
    total++; if (load_data !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got=%h want=deadbeef", load_data); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL lw_done_pulse got=%h want=0", done); end
  endtask

  task automatic test_sb_wait();
    bif.bus_busy = 1'b1;
    issue(0, 1, 0, 1, 32'h203, 32'h000000A5);
    drop_req();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      total++; if (bif.bus_wen !== 1'b1 || bif.bus_ren !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL sb_wen_c%0d got=wen%h ren%h done%h want=1 0 0", k, bif.bus_wen, bif.bus_ren, done); end
      bif.bus_busy = (k < 4);
      if (k < 4) @(posedge clk);
    end
    total++; if (bif.bus_sel !== 4'b1000 || bif.bus_wdata !== 32'hA5A5A5A5 || bif.bus_addr !== 32'h200) begin bad++; $display("FAIL sb_bus got=sel%h wd%h a%h want=8 a5a5a5a5 200", bif.bus_sel, bif.bus_wdata, bif.bus_addr); end
    @(negedge clk);
    total++; if (done !== 1'b1 || bif.bus_wen !== 1'b0) begin bad++; $display("FAIL sb_c5 got=done%h wen%h want=1 0", done, bif.bus_wen); end
    total++; if (load_data !== 32'hDEADBEEF) begin bad++; $display("FAIL sb_load_kept got=%h want=deadbeef", load_data); end
  endtask

  task automatic test_lb();
    bif.bus_rdata = 32'h12348056; bif.bus_busy = 1'b0;
    issue(1, 0, 1, 0, 32'h41, 32'h0);
    drop_req();
    @(negedge clk);
    total++; if (bif.bus_sel !== 4'b0010 || bif.bus_addr !== 32'h40) begin bad++; $display("FAIL lb_sel got=sel%h a%h want=2 40", bif.bus_sel, bif.bus_addr); end
    @(negedge clk);
    total++; if (done !== 1'b1 || load_data !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_neg got=done%h %h want=1 ffffff80", done, load_data); end
    issue(1, 0, 1, 0, 32'h40, 32'h0);
    drop_req();
    @(negedge clk); @(negedge clk);
    total++; if (done !== 1'b1 || load_data !== 32'h00000056) begin bad++; $display("FAIL lb_pos got=done%h %h want=1 00000056", done, load_data); end
  endtask

  task automatic test_rw_collision();
    bif.bus_rdata = 32'h99999999;
    issue(1, 1, 0, 0, 32'h300, 32'h11223344);
    drop_req();
    @(negedge clk);
    total++; if (bif.bus_wen !== 1'b1 || bif.bus_ren !== 1'b0) begin bad++; $display("FAIL rw_strobes got=wen%h ren%h want=1 0", bif.bus_wen, bif.bus_ren); end
    total++; if (bif.bus_wdata !== 32'h11223344 || bif.bus_sel !== 4'hF) begin bad++; $display("FAIL rw_bus got=wd%h sel%h want=11223344 f", bif.bus_wdata, bif.bus_sel); end
    @(negedge clk);
    total++; if (done !== 1'b1 || load_data !== 32'h00000056) begin bad++; $display("FAIL rw_load_kept got=done%h %h want=1 00000056", done, load_data); end
  endtask

  task automatic test_reset_mid_req();
    bif.bus_busy = 1'b1;
    issue(1, 0, 0, 0, 32'h180, 32'h0);
    drop_req();
    @(negedge clk);
    total++; if (bif.bus_ren !== 1'b1) begin bad++; $display("FAIL mid_ren got=%h want=1", bif.bus_ren); end
    #1 nRst = 1'b0;
    #1;
    total++; if (bif.bus_ren !== 1'b0 || bif.bus_wen !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL mid_drop got=ren%h wen%h stall%h want=0 0 0", bif.bus_ren, bif.bus_wen, stall); end
    total++; if (load_data !== 32'h0 || bif.bus_addr !== 32'h0 || bif.bus_sel !== 4'h0 || bif.bus_wdata !== 32'h0) begin bad++; $display("FAIL mid_regs got=%h %h %h %h want=0", load_data, bif.bus_addr, bif.bus_sel, bif.bus_wdata); end
    @(negedge clk); nRst = 1'b1;
    bif.bus_busy = 1'b0; bif.bus_rdata = 32'hCAFEF00D;
    issue(1, 0, 0, 0, 32'h104, 32'h0);
    drop_req();
    @(negedge clk);
    total++; if (bif.bus_ren !== 1'b1 || bif.bus_addr !== 32'h104) begin bad++; $display("FAIL mid_relw_c1 got=ren%h a%h want=1 104", bif.bus_ren, bif.bus_addr); end
    @(negedge clk);
    total++; if (done !== 1'b1 || load_data !== 32'hCAFEF00D) begin bad++; $display("FAIL mid_relw_c2 got=done%h %h want=1 cafef00d", done, load_data); end
  endtask

  task automatic test_misaligned_sw();
    bif.bus_busy = 1'b0;
    issue(0, 1, 0, 0, 32'h102, 32'h55667788);
    @(negedge clk);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL mis_c0 got=%h want=1", stall); end
    drop_req();
    @(negedge clk);
`ifdef MISALIGN_TRAP_EN
    total++; if (done !== 1'b1 || misaligned !== 1'b1 || bif.bus_wen !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL mis_trap got=done%h mis%h wen%h stall%h want=1 1 0 0", done, misaligned, bif.bus_wen, stall); end
`else
    total++; if (bif.bus_wen !== 1'b1 || bif.bus_addr !== 32'h100 || bif.bus_sel !== 4'hF) begin bad++; $display("FAIL mis_bus got=wen%h a%h sel%h want=1 100 f", bif.bus_wen, bif.bus_addr, bif.bus_sel); end
    @(negedge clk);
    total++; if (done !== 1'b1 || misaligned !== 1'b0) begin bad++; $display("FAIL mis_done got=done%h mis%h want=1 0", done, misaligned); end
`endif
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sb_wait();
    test_lb();
    test_rw_collision();
    test_reset_mid_req();
    test_misaligned_sw();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
